dc_token_src_channel: RTL and testbench

// Source (write) half of the token-based dual-clock FIFO carrying one AXI channel out of pulp_soc
//   (e.g. data_master AW/AR/W, which produce *_writetoken_o and consume *_readpointer_i).
// - Accepts a valid/ready payload stream in the SoC clock domain.
// - Stores payloads in a BUFFER_WIDTH-entry register buffer.
// - Publishes the write pointer as a Johnson-coded token; only one bit changes per step, so it is CDC-safe.
// - The consumer domain reads entries straight from data_async_o and returns its Johnson read pointer,

---
 rtl/dc_token_src_channel.sv | 79 +++++++
 tb/tb_dc_token_src_channel.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dc_token_src_channel.sv
// Write side of a token-based dual-clock FIFO for one AXI channel.
// Payloads go into a register buffer; the write pointer leaves as a Johnson token.
module dc_token_src_channel #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_WIDTH = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               valid_i,
    output logic                               ready_o,
    input  logic [DATA_WIDTH-1:0]              data_i,
    output logic [BUFFER_WIDTH-1:0]            writetoken_o,
    input  logic [BUFFER_WIDTH-1:0]            readpointer_i,
    output logic [BUFFER_WIDTH*DATA_WIDTH-1:0] data_async_o,
    output logic [$clog2(BUFFER_WIDTH):0]      level_o
);

    localparam int N  = BUFFER_WIDTH;
    localparam int LW = $clog2(N) + 1;
    localparam int IW = LW - 1;

    logic [N-1:0]                 tok_q;
    logic [N-1:0]                 sync_q [SYNC_STAGES];
    logic [N-1:0][DATA_WIDTH-1:0] mem_q;
    logic [N-1:0]                 rd_sync;
    logic [LW-1:0]                wr_bin;
    logic [LW-1:0]                rd_bin;
    logic [IW-1:0]                wr_idx;
    logic                         full;
    logic                         push;

    // 2N is a power of two, so LW-bit wrap gives the mod-2N arithmetic.
    function automatic logic [LW-1:0] tok2bin(input logic [N-1:0] t);
        logic [LW-1:0] pc;
        pc = '0;
        for (int i = 0; i < N; i++) begin
            pc = pc + LW'(t[i]);
        end
        return t[0] ? pc : LW'(0) - pc;
    endfunction

    assign rd_sync = sync_q[SYNC_STAGES-1];
    assign wr_bin  = tok2bin(tok_q);
    assign rd_bin  = tok2bin(rd_sync);
    assign wr_idx  = wr_bin[IW-1:0];
    assign full    = (tok_q == ~rd_sync);
    assign push    = valid_i & ~full;

    assign ready_o      = ~full;
    assign writetoken_o = tok_q;
    assign data_async_o = mem_q;
    assign level_o      = wr_bin - rd_bin;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= readpointer_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Data and token move on the same edge; the reader's sync delay covers settling.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tok_q <= '0;
            mem_q <= '0;
        end else if (push) begin
            mem_q[wr_idx] <= data_i;
            tok_q         <= {tok_q[N-2:0], ~tok_q[N-1]};
        end
    end

endmodule

// File: tb/tb_dc_token_src_channel.sv
// Scoreboard bench for dc_token_src_channel against a counter-based model.
// Random traffic, fill/drain, wrap-around and asynchronous reset.
module tb_dc_token_src_channel;

    localparam int DW = 32;
    localparam int N  = 8;
    localparam int SS = 2;

    logic                 clk = 1'b0;
    logic                 rstn_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [DW-1:0]        data_i;
    logic [N-1:0]         writetoken_o;
    logic [N-1:0]         readpointer_i;
    logic [N*DW-1:0]      data_async_o;
    logic [$clog2(N):0]   level_o;

    dc_token_src_channel #(
        .DATA_WIDTH(DW), .BUFFER_WIDTH(N), .SYNC_STAGES(SS)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_i(data_i), .writetoken_o(writetoken_o),
        .readpointer_i(readpointer_i), .data_async_o(data_async_o),
        .level_o(level_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  tok;
        int            idx;
        logic [DW-1:0] data;
    } exp_t;

    int            errors = 0;
    int            checks = 0;
    exp_t          sbq[$];
    int            wcnt;
    int            rcnt;
    int            rs_q[$];
    logic [DW-1:0] mem[N];

    // Johnson token for a count of k steps from zero.
    function automatic logic [N-1:0] johnson(input int k);
        int m;
        logic [N-1:0] t;
        m = k % (2 * N);
        t = '0;
        for (int i = 0; i < N; i++) begin
            if (m <= N) t[i] = (i < m);
            else        t[i] = (i >= m - N);
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int synced();
        return rs_q[0];
    endfunction

    task automatic model_reset();
        wcnt = 0;
        rcnt = 0;
        rs_q = {};
        for (int i = 0; i < SS; i++) rs_q.push_back(0);
        for (int i = 0; i < N; i++) mem[i] = '0;
        sbq.delete();
    endtask

    // One clock: apply inputs, check state at negedge, update model at posedge.
    task automatic cycle(input bit v, input logic [DW-1:0] d, output bit acc);
        bit rdy;
        valid_i       = v;
        data_i        = d;
        readpointer_i = johnson(rcnt);
        @(negedge clk);
        rdy = (wcnt - synced()) < N;
        chk("ready", 64'(ready_o), 64'(rdy));
        chk("level", 64'(level_o), 64'(wcnt - synced()));
        chk("token", 64'(writetoken_o), 64'(johnson(wcnt)));
        for (int i = 0; i < N; i++)
            chk($sformatf("entry%0d", i), 64'(data_async_o[i*DW +: DW]), 64'(mem[i]));
        @(posedge clk);
        acc = v && rdy;
        if (acc) begin
            mem[wcnt % N] = d;
            wcnt++;
            sbq.push_back('{tok: johnson(wcnt), idx: (wcnt - 1) % N, data: d});
        end
        rs_q.push_back(rcnt);
        void'(rs_q.pop_front());
        #1;
    endtask

    // Monitor: every token step must match the oldest pending write.
    initial begin
        logic [N-1:0] prev;
        exp_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rstn_i) begin
                prev = writetoken_o;
            end else if (writetoken_o !== prev) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_step", 64'(writetoken_o), 64'(prev));
                end else begin
                    e = sbq.pop_front();
                    chk("mon_token", 64'(writetoken_o), 64'(e.tok));
                    chk("mon_data", 64'(data_async_o[e.idx*DW +: DW]), 64'(e.data));
                end
                prev = writetoken_o;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(ready_o), 64'd1);
        chk({tag, "_token"}, 64'(writetoken_o), 64'd0);
        chk({tag, "_level"}, 64'(level_o), 64'd0);
        chk({tag, "_data"}, 64'(data_async_o == '0), 64'd1);
    endtask

    initial begin
        bit acc;
        int n;
        model_reset();
        rstn_i        = 1'b0;
        valid_i       = 1'b0;
        data_i        = '0;
        readpointer_i = '0;
        #12;
        chk_reset_values("rst");
        #5 rstn_i = 1'b1;
        @(posedge clk);
        #1;

        // Fill with 0xA0..0xA7, then a held write must be refused.
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, DW'(32'hA0 + i), acc);
            chk("fill_acc", 64'(acc), 64'd1);
        end
        chk("full_token", 64'(writetoken_o), 64'hFF);
        chk("full_ready", 64'(ready_o), 64'd0);
        chk("full_level", 64'(level_o), 64'd8);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 32'hBB, acc);
            chk("full_refuse", 64'(acc), 64'd0);
        end

        // Free one entry; ready returns after the sync delay.
        rcnt = 1;
        cycle(1'b0, '0, acc);
        chk("free_ready_early", 64'(ready_o), 64'd0);
        cycle(1'b0, '0, acc);
        chk("free_ready", 64'(ready_o), 64'd1);
        chk("free_level", 64'(level_o), 64'd7);
        cycle(1'b1, 32'hC0, acc);
        chk("c0_acc", 64'(acc), 64'd1);
        chk("c0_token", 64'(writetoken_o), 64'hFE);
        chk("c0_entry0", 64'(data_async_o[DW-1:0]), 64'hC0);

        // Stream with the reader three entries behind; token wraps.
        n = 0;
        for (int c = 0; c < 400 && n < 40; c++) begin
            if (wcnt - 3 > rcnt) rcnt = wcnt - 3;
            cycle(($urandom % 4) != 0, $urandom, acc);
            if (acc) n++;
        end
        chk("stream_count", 64'(n), 64'd40);

        // Fill up, then free and offer a write on the same edge.
        for (int c = 0; c < 40 && ready_o; c++)
            cycle(1'b1, $urandom, acc);
        chk("refill_full", 64'(ready_o), 64'd0);
        rcnt = rcnt + 1;
        cycle(1'b1, 32'h5A5A0001, acc);
        chk("same_edge_refuse1", 64'(acc), 64'd0);
        cycle(1'b1, 32'h5A5A0002, acc);
        chk("same_edge_refuse2", 64'(acc), 64'd0);
        cycle(1'b1, 32'h5A5A0003, acc);
        chk("same_edge_accept", 64'(acc), 64'd1);

        // Drain, write five, then reset asynchronously mid-burst.
        rcnt = wcnt;
        for (int i = 0; i < SS + 1; i++) cycle(1'b0, '0, acc);
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, acc);
        chk("pre_reset_level", 64'(level_o), 64'd5);
        valid_i = 1'b1;
        #1 rstn_i = 1'b0;
        #1;
        chk_reset_values("async_rst");
        model_reset();
        valid_i       = 1'b0;
        readpointer_i = '0;
        @(negedge clk);
        #2 rstn_i = 1'b1;
        @(posedge clk);
        #1;

        // Recovery traffic after reset.
        for (int c = 0; c < 30; c++) begin
            if (wcnt - 2 > rcnt) rcnt = wcnt - 2;
            cycle($urandom % 2, $urandom, acc);
        end
        cycle(1'b0, '0, acc);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
